xor_gate: RTL and testbench
===========================

Name: xor_gate

Overview:
- Registered, parameterizable bitwise XOR unit with valid/ready handshake on input and output.
- Each accepted beat produces c = a ^ b, plus the reduction parity of c and the Hamming distance between a and b (popcount of c).
- Sits as a one-stage pipeline element in datapaths needing difference/parity detection; at WIDTH=1 it behaves as a clocked 2-input XOR gate.

Parameters:
- WIDTH, 1, operand/result width in bits (legal range 1..64).
- HD_W, $clog2(WIDTH+1), width of Hamming-distance output; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  a/b valid this cycle.
- in_ready  output  1  block can accept a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  c/parity/hdist hold a valid result.
- out_ready  input  1  downstream accepts the result this cycle.
- c  output  WIDTH  registered a ^ b.
- parity  output  1  registered XOR-reduction of c (1 = odd number of differing bits).
- hdist  output  HD_W  registered count of set bits in c (0..WIDTH).

Behaviour:
- Reset (rst=1 at posedge): out_valid=0, c=0, parity=0, hdist=0; in_valid is ignored during the reset cycle. rst has priority over all other events.
- in_ready = !out_valid || out_ready. It is combinational, with no dependence on in_valid. It is 1 immediately after reset.
- Accept: in_valid && in_ready at a posedge. On that edge c <= a ^ b, parity <= ^(a ^ b), hdist <= popcount(a ^ b), out_valid <= 1. Latency is exactly 1 cycle.
- Drain: out_valid && out_ready with no accept on the same edge gives out_valid <= 0. c/parity/hdist keep their last values; they are don't-care while out_valid=0, but the implementation must hold them.
- Simultaneous drain + accept (out_valid=1, out_ready=1, in_valid=1): the new result replaces the old one and out_valid stays 1. This gives full throughput of one beat per cycle.
- Backpressure (out_valid=1, out_ready=0): in_ready=0, and c/parity/hdist/out_valid stay stable until out_ready is asserted.
- a/b are sampled only on accept. Changes at other times have no effect.
- Arithmetic: c is purely bitwise. parity == hdist[0] at all times when out_valid=1. hdist is an unsigned count and never exceeds WIDTH.
- Reset mid-operation: a pending unconsumed result is discarded and out_valid=0 on the next cycle.
- There are no combinational paths from a/b to any output.

Optional Feature:
- Macro XOR_GATE_ACCUM_EN.
- When defined, the block adds input accum_clr (1 bit) and output acc (WIDTH).
  - On each accept: acc <= (accum_clr ? 0 : acc) ^ (a ^ b).
  - accum_clr without an accept: acc <= 0.
  - Reset: acc=0.
  - acc updates on the same edge as c, so it is a running XOR of all results since the last clear.
- When undefined, accum_clr and acc are absent from the port list, no accumulator logic exists, and all other behaviour is identical.

Test Plan:
- WIDTH=1, out_ready=1, apply beats (a,b) = (0,0),(1,0),(0,1),(1,1) on consecutive cycles. Required: c = 0,1,1,0 one cycle after each beat; parity equals c; hdist = 0,1,1,0; out_valid stays 1 continuously.
- WIDTH=8, a=8'hF0, b=8'h3C. Required: c=8'hCC, parity=0, hdist=4. Then a=8'hFF, b=8'h00: c=8'hFF, parity=0, hdist=8. Then a=b=8'hA5: c=0, hdist=0.
- Backpressure, WIDTH=8: accept a=8'h01, b=8'h00, then hold out_ready=0 for 3 cycles while in_valid=1 with a=8'hFF. Required: in_ready=0, c stays 8'h01 with hdist=1. On out_ready=1, the 8'hFF result appears on the next cycle.
- Reset mid-operation: with out_valid=1 and c=8'hCC, pulse rst for 1 cycle with in_valid=1. Required: next cycle out_valid=0, c=0, hdist=0, in_ready=1, and no beat is captured during reset.
- Drain without refill: out_valid=1, out_ready=1, in_valid=0. Required: out_valid=0 next cycle and c holds its value.
- With XOR_GATE_ACCUM_EN, WIDTH=8: accept results 8'h0F, 8'hF0, 8'hFF. Required: acc = 8'h0F, 8'hFF, 8'h00. Then accept 8'h11 with accum_clr=1: acc=8'h11.

Source files
------------

// File: rtl/xor_gate.sv
//------------------------------------------------------------------------------
// Module  : xor_gate
// Brief   : Registered bitwise XOR with parity and Hamming distance, valid/ready
//           handshake. Optional running XOR accumulator under XOR_GATE_ACCUM_EN.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module xor_gate #(
    parameter int  WIDTH = 1,
    localparam int HD_W  = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic             parity,
`ifdef XOR_GATE_ACCUM_EN
    input  logic             accum_clr,
    output logic [WIDTH-1:0] acc,
`endif
    output logic [HD_W-1:0]  hdist
);

    logic             r_out_valid;
    logic [WIDTH-1:0] r_c;
    logic             r_parity;
    logic [HD_W-1:0]  r_hdist;

    logic             w_accept;
    logic [WIDTH-1:0] w_c;
    logic             w_parity;
    logic [HD_W-1:0]  w_hdist;

    // The output slot frees up on the same edge it drains, giving one beat per cycle.
    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    always_comb begin
        w_c      = a ^ b;
        w_parity = ^w_c;
        w_hdist  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_hdist = w_hdist + HD_W'(w_c[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_c         <= '0;
            r_parity    <= 1'b0;
            r_hdist     <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_c         <= w_c;
            r_parity    <= w_parity;
            r_hdist     <= w_hdist;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

`ifdef XOR_GATE_ACCUM_EN
    logic [WIDTH-1:0] r_acc;

    // A clear coinciding with an accept restarts the running XOR from this beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (w_accept) begin
            r_acc <= (accum_clr ? '0 : r_acc) ^ w_c;
        end else if (accum_clr) begin
            r_acc <= '0;
        end
    end

    assign acc = r_acc;
`endif

    assign out_valid = r_out_valid;
    assign c         = r_c;
    assign parity    = r_parity;
    assign hdist     = r_hdist;

endmodule

`default_nettype wire

// File: tb/tb_xor_gate.sv
//------------------------------------------------------------------------------
// Module  : tb_xor_gate
// Brief   : Self-checking bench for xor_gate at WIDTH=1 and WIDTH=8.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_xor_gate;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=8 instance
    logic       rst8 = 1'b1, iv8 = 1'b0, ordy8 = 1'b1, clr8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       irdy8, ov8, par8;
    logic [7:0] c8, acc8;
    logic [3:0] hd8;

    // WIDTH=1 instance
    logic       rst1 = 1'b1, iv1 = 1'b0, ordy1 = 1'b1, clr1 = 1'b0;
    logic       a1 = 1'b0, b1 = 1'b0;
    logic       irdy1, ov1, par1, c1, acc1;
    logic [0:0] hd1;

    xor_gate #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst8), .in_valid(iv8), .in_ready(irdy8),
        .a(a8), .b(b8), .out_valid(ov8), .out_ready(ordy8),
        .c(c8), .parity(par8),
`ifdef XOR_GATE_ACCUM_EN
        .accum_clr(clr8), .acc(acc8),
`endif
        .hdist(hd8)
    );

    xor_gate #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst1), .in_valid(iv1), .in_ready(irdy1),
        .a(a1), .b(b1), .out_valid(ov1), .out_ready(ordy1),
        .c(c1), .parity(par1),
`ifdef XOR_GATE_ACCUM_EN
        .accum_clr(clr1), .acc(acc1),
`endif
        .hdist(hd1)
    );

`ifndef XOR_GATE_ACCUM_EN
    assign acc8 = '0;
    assign acc1 = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    // Reference state for the WIDTH=8 instance
    logic       m_valid = 1'b0;
    logic [7:0] m_c     = '0;
    int         m_hd    = 0;
    logic [7:0] m_acc   = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge (or at time 0); returns just after the next falling edge.
    task automatic step8(input logic r, input logic iv, input logic [7:0] ai,
                         input logic [7:0] bi, input logic ordy, input logic clr);
        logic take;
        rst8 = r; iv8 = iv; a8 = ai; b8 = bi; ordy8 = ordy; clr8 = clr;
        #1;
        chk("in_ready8", 64'(irdy8), 64'(!m_valid || ordy));
        take = !r && iv && (!m_valid || ordy);
        if (r) begin
            m_valid = 1'b0; m_c = '0; m_hd = 0; m_acc = '0;
        end else if (take) begin
            m_valid = 1'b1;
            m_c     = ai ^ bi;
            m_hd    = $countones(ai ^ bi);
            m_acc   = (clr ? 8'h00 : m_acc) ^ (ai ^ bi);
        end else begin
            if (m_valid && ordy) m_valid = 1'b0;
            if (clr) m_acc = '0;
        end
        @(posedge clk);
        @(negedge clk);
        chk("out_valid8", 64'(ov8), 64'(m_valid));
        chk("c8", 64'(c8), 64'(m_c));
        chk("hdist8", 64'(hd8), 64'(m_hd));
        chk("parity8", 64'(par8), 64'(m_hd % 2));
`ifdef XOR_GATE_ACCUM_EN
        chk("acc8", 64'(acc8), 64'(m_acc));
`endif
    endtask

    task automatic step1(input logic ai, input logic bi, input logic exp_c);
        rst1 = 1'b0; iv1 = 1'b1; ordy1 = 1'b1; a1 = ai; b1 = bi;
        @(posedge clk);
        @(negedge clk);
        chk("c1", 64'(c1), 64'(exp_c));
        chk("parity1", 64'(par1), 64'(exp_c));
        chk("hdist1", 64'(hd1), 64'(exp_c));
        chk("out_valid1", 64'(ov1), 64'd1);
    endtask

    initial begin
        // Reset both instances
        step8(1'b1, 1'b1, 8'hAA, 8'h55, 1'b1, 1'b0);
        step8(1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        rst1 = 1'b0; iv1 = 1'b0;
        chk("rst_out_valid1", 64'(ov1), 64'd0);
        chk("rst_in_ready1", 64'(irdy1), 64'd1);
        chk("rst_c8", 64'(c8), 64'd0);

        // WIDTH=1 truth table, back to back
        step1(1'b0, 1'b0, 1'b0);
        step1(1'b1, 1'b0, 1'b1);
        step1(1'b0, 1'b1, 1'b1);
        step1(1'b1, 1'b1, 1'b0);
        iv1 = 1'b0;

        // WIDTH=8 directed values
        step8(1'b0, 1'b1, 8'hF0, 8'h3C, 1'b1, 1'b0);
        chk("dir_c_CC", 64'(c8), 64'hCC);
        chk("dir_hd_4", 64'(hd8), 64'd4);
        step8(1'b0, 1'b1, 8'hFF, 8'h00, 1'b1, 1'b0);
        chk("dir_hd_8", 64'(hd8), 64'd8);
        step8(1'b0, 1'b1, 8'hA5, 8'hA5, 1'b1, 1'b0);
        chk("dir_c_0", 64'(c8), 64'h00);

        // Drain without refill
        step8(1'b0, 1'b0, 8'h12, 8'h34, 1'b1, 1'b0);
        chk("drain_ov", 64'(ov8), 64'd0);

        // Backpressure
        step8(1'b0, 1'b1, 8'h01, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step8(1'b0, 1'b1, 8'hFF, 8'h00, 1'b0, 1'b0);
            chk("bp_c_held", 64'(c8), 64'h01);
            chk("bp_in_ready", 64'(irdy8), 64'd0);
        end
        step8(1'b0, 1'b1, 8'hFF, 8'h00, 1'b1, 1'b0);
        chk("bp_release_c", 64'(c8), 64'hFF);

        // Reset with a pending result
        step8(1'b0, 1'b1, 8'hF0, 8'h3C, 1'b1, 1'b0);
        step8(1'b1, 1'b1, 8'h0F, 8'h00, 1'b0, 1'b0);
        chk("midrst_ov", 64'(ov8), 64'd0);
        chk("midrst_c", 64'(c8), 64'h00);
        chk("midrst_in_ready", 64'(irdy8), 64'd1);

`ifdef XOR_GATE_ACCUM_EN
        step8(1'b0, 1'b1, 8'h0F, 8'h00, 1'b1, 1'b0);
        chk("acc_0F", 64'(acc8), 64'h0F);
        step8(1'b0, 1'b1, 8'hF0, 8'h00, 1'b1, 1'b0);
        chk("acc_FF", 64'(acc8), 64'hFF);
        step8(1'b0, 1'b1, 8'hFF, 8'h00, 1'b1, 1'b0);
        chk("acc_00", 64'(acc8), 64'h00);
        step8(1'b0, 1'b1, 8'h11, 8'h00, 1'b1, 1'b1);
        chk("acc_clr_11", 64'(acc8), 64'h11);
`endif

        // Randomised traffic against the reference
        for (int i = 0; i < 300; i++) begin
            step8(($urandom_range(0, 49) == 0), 1'($urandom), 8'($urandom), 8'($urandom),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
